score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Receiving end of the game controller's score-update interface.
- Captures one-cycle binary `scoreUpdate` values (alien or bonus-ship kills) and queues them.
- Converts each queued value to BCD with a sequential double-dabble, then adds it digit-serially into a 4-digit BCD score.
- Tracks the high score across games and emits a one-shot extra-life pulse. Score and high score feed the HUD digit drawers.

Parameters:
- FIFO_DEPTH, 4, update queue entries (power of 2, ≥2)
- EXTRA_LIFE_AT, 16'h1500, BCD score threshold for the extra-life award (0 disables)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- scoreUpdate  in  8  unsigned binary points; nonzero value = valid update for that single cycle
- startGame  in  1  new-game indication from game controller (level)
- standBy  in  1  high when not in active play
- gameEnded  in  1  high in game-over screens
- score  out  16  current score, 4 packed BCD digits (15:12 = thousands)
- highScore  out  16  best score since reset, packed BCD
- extraLifePulse  out  1  one-cycle pulse on threshold crossing
- busy  out  1  engine not IDLE or FIFO non-empty
- overflow  out  1  sticky: an update was dropped

Behaviour:
- Reset values: score=0, highScore=0, extraLifePulse=0, busy=0, overflow=0. FIFO is empty, engine is in IDLE, awardGiven=0.

Capture:
- Define accept = (scoreUpdate≠0) && !standBy && !gameEnded && !startGame.
- On accept, the value is pushed into the FIFO.
- Accept when full: the value is dropped and overflow←1.
- Push and pop in the same cycle are both performed; the count is unchanged.

Engine FSM:
- IDLE: if the FIFO is non-empty, pop the head into an 8-bit shift register, clear the 12-bit BCD accumulator, bitCnt=0, go to CONV.
- CONV: one double-dabble step per clock (add 3 to each BCD nibble ≥5, then shift left by one bit from the binary register). After 8 clocks (bitCnt=7), go to ADD with digit=0, carry=0.
- ADD: per clock, sum = score[digit] + conv[digit] + carry (conv digit 3 = 0).
  - If sum>9: write sum−10 to the working register and set carry=1.
  - Otherwise: write sum and set carry=0.
  - After digit 3, go to COMMIT.
- COMMIT (1 clock):
  - score ← 16'h9999 if the final carry is 1 (saturate), else the working register.
  - If the new score > highScore (unsigned compare of packed BCD), highScore ← new score.
  - If EXTRA_LIFE_AT≠0, awardGiven=0, and the new score ≥ EXTRA_LIFE_AT: pulse extraLifePulse for exactly this cycle and set awardGiven=1.
  - Go to IDLE.

Latency and throughput:
- Update sampled at edge N → score valid after edge N+14 (push N, pop N+1, CONV 8, ADD 4, COMMIT 1).
- Throughput is one update per 14 clocks; back-to-back updates queue.

New game:
- While startGame=1: score←0, FIFO flushed, engine forced to IDLE, awardGiven←0, overflow←0.
- highScore is retained. An in-flight update is discarded without commit.

Other rules:
- score updates only in COMMIT; it never shows partial sums.
- Asynchronous reset mid-operation returns everything to the reset values immediately.
- Saturated 9999 stays at 9999 on further updates, which are still processed.
- busy = (state≠IDLE) || FIFO non-empty.

Test Plan:
1. Reset, standBy=0, single pulse scoreUpdate=30 at cycle N → score=16'h0030 exactly after edge N+14, highScore=16'h0030, busy low from N+15.
2. Pulses 100, 20, 10 on cycles N, N+2, N+4 → score steps 0100, 0120, 0130 at N+14, N+28, N+42; overflow=0.
3. Six pulses of 10 on consecutive even cycles with FIFO_DEPTH=4 → five are accepted (one popped before a later push), one is dropped, overflow=1, final score 0050; startGame clears overflow.
4. Preload score 9990 via updates, then apply 30 → score saturates at 9999; one further update leaves 9999.
5. Updates totaling 1490, then 20 → extraLifePulse high for exactly one cycle at the 1510 commit. A subsequent 10 → no pulse. After startGame and a new 1500 total → pulse again.
6. Score 0250 and highScore 0250; startGame asserted mid-CONV of an update 40 → score=0 next cycle, highScore stays 0250, no commit. A pulse while standBy=1 or gameEnded=1 is ignored (score stays 0).

Source files
------------

// File: rtl/score_keeper_if.sv
// score_keeper_if: score-update bus between the game controller and the
// score keeper.
//   master : game controller (drives scoreUpdate/startGame/standBy/gameEnded,
//            observes score/highScore/extraLifePulse/busy/overflow)
//   slave  : score_keeper
interface score_keeper_if;
    logic [7:0]  scoreUpdate;     // binary points, nonzero = valid this cycle
    logic        startGame;       // level: new game, clears score/queue
    logic        standBy;         // not in active play
    logic        gameEnded;       // game-over screens
    logic [15:0] score;           // packed BCD, 15:12 = thousands
    logic [15:0] highScore;       // packed BCD, best since reset
    logic        extraLifePulse;  // one cycle on threshold crossing
    logic        busy;            // engine active or queue non-empty
    logic        overflow;        // sticky: an update was dropped

    modport master (
        output scoreUpdate, startGame, standBy, gameEnded,
        input  score, highScore, extraLifePulse, busy, overflow
    );

    modport slave (
        input  scoreUpdate, startGame, standBy, gameEnded,
        output score, highScore, extraLifePulse, busy, overflow
    );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: queues binary score updates, converts each to BCD with a
// sequential double-dabble (8 clocks), adds it digit-serially into a 4-digit
// packed-BCD score (4 clocks) and commits it (1 clock). Tracks the high score
// and raises a one-shot extra-life pulse.
//   clk, resetN : clock, asynchronous active-low reset
//   bus         : score_keeper_if.slave (update inputs, score/status outputs)
module score_keeper #(
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [15:0] EXTRA_LIFE_AT = 16'h1500
) (
    input  logic           clk,
    input  logic           resetN,
    score_keeper_if.slave  bus
);
    localparam int         PW    = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CONV, ADD, COMMIT} state_t;

    state_t        state_q;
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic [19:0]   conv_q;      // {bcd[11:0], bin[7:0]}
    logic [2:0]    bit_cnt_q;
    logic [1:0]    digit_q;
    logic          carry_q;
    logic [15:0]   work_q;
    logic [15:0]   score_q, high_q;
    logic          award_q, pulse_q, overflow_q;

    logic          accept, full, empty, push, pop;
    logic [3:0]    score_dig_d, conv_dig_d;
    logic [4:0]    sum_d;
    logic [15:0]   new_score_d;

    assign accept = (bus.scoreUpdate != 8'd0) && !bus.standBy && !bus.gameEnded && !bus.startGame;
    assign full   = (count_q == DEPTH);
    assign empty  = (count_q == '0);
    assign push   = accept && !full;
    assign pop    = (state_q == IDLE) && !empty;

    // One double-dabble step: correct each BCD nibble >= 5, then shift.
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        for (int i = 0; i < 3; i++)
            if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
        return t << 1;
    endfunction

    always_comb begin
        score_dig_d = 4'd0;
        conv_dig_d  = 4'd0;
        case (digit_q)
            2'd0: begin score_dig_d = score_q[3:0];   conv_dig_d = conv_q[11:8];  end
            2'd1: begin score_dig_d = score_q[7:4];   conv_dig_d = conv_q[15:12]; end
            2'd2: begin score_dig_d = score_q[11:8];  conv_dig_d = conv_q[19:16]; end
            default: begin score_dig_d = score_q[15:12]; conv_dig_d = 4'd0;      end
        endcase
        sum_d       = {1'b0, score_dig_d} + {1'b0, conv_dig_d} + {4'd0, carry_q};
        // A carry out of the thousands digit means the score passed 9999.
        new_score_d = carry_q ? 16'h9999 : work_q;
    end

    // Queue storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= bus.scoreUpdate;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            conv_q     <= '0;
            bit_cnt_q  <= '0;
            digit_q    <= '0;
            carry_q    <= 1'b0;
            work_q     <= '0;
            score_q    <= '0;
            high_q     <= '0;
            award_q    <= 1'b0;
            pulse_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (bus.startGame) begin
            // New game: drop queue and any in-flight update, keep high score.
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            score_q    <= '0;
            award_q    <= 1'b0;
            pulse_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (accept && full) overflow_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        conv_q    <= {12'd0, fifo_q[rd_ptr_q]};
                        bit_cnt_q <= '0;
                        state_q   <= CONV;
                    end
                end
                CONV: begin
                    conv_q    <= dd_step(conv_q);
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        digit_q <= '0;
                        carry_q <= 1'b0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    if (sum_d > 5'd9) begin
                        work_q[{digit_q, 2'b00} +: 4] <= 4'(sum_d - 5'd10);
                        carry_q <= 1'b1;
                    end else begin
                        work_q[{digit_q, 2'b00} +: 4] <= sum_d[3:0];
                        carry_q <= 1'b0;
                    end
                    digit_q <= digit_q + 1'b1;
                    if (digit_q == 2'd3) state_q <= COMMIT;
                end
                default: begin // COMMIT
                    score_q <= new_score_d;
                    if (new_score_d > high_q) high_q <= new_score_d;
                    if ((EXTRA_LIFE_AT != 16'h0) && !award_q && (new_score_d >= EXTRA_LIFE_AT)) begin
                        pulse_q <= 1'b1;
                        award_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.score          = score_q;
    assign bus.highScore      = high_q;
    assign bus.extraLifePulse = pulse_q;
    assign bus.overflow       = overflow_q;
    assign bus.busy           = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: latency, queueing, overflow, saturation,
// extra-life award, new-game flush and gated capture.
module tb_score_keeper;
    logic clk;
    logic resetN;
    int   checks;
    int   errors;

    score_keeper_if bus();

    score_keeper #(.FIFO_DEPTH(4), .EXTRA_LIFE_AT(16'h1500)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push one value, then wait long enough for it to commit, counting
    // cycles where the extra-life pulse is high.
    task automatic send(input logic [7:0] v, output int pulses);
        pulses = 0;
        @(negedge clk) bus.scoreUpdate = v;
        @(negedge clk) bus.scoreUpdate = 8'd0;
        repeat (16) begin
            @(negedge clk);
            if (bus.extraLifePulse) pulses++;
        end
    endtask

    task automatic start_game();
        @(negedge clk) bus.startGame = 1'b1;
        @(negedge clk) bus.startGame = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        bus.scoreUpdate = 8'd0;
        bus.startGame = 1'b0;
        bus.standBy = 1'b0;
        bus.gameEnded = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.score !== 16'h0 || bus.highScore !== 16'h0 || bus.extraLifePulse !== 1'b0 ||
            bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: score=%h hs=%h pulse=%b busy=%b ovf=%b, want all zero",
                     bus.score, bus.highScore, bus.extraLifePulse, bus.busy, bus.overflow);
        end
        resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        @(negedge clk) bus.scoreUpdate = 8'd30;
        @(posedge clk);                       // edge N
        @(negedge clk) bus.scoreUpdate = 8'd0;
        repeat (13) @(posedge clk);           // edge N+13
        #1;
        checks++;
        if (bus.score !== 16'h0000 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_early: score=%h busy=%b, want 0000/1", bus.score, bus.busy);
        end
        @(posedge clk); #1;                   // edge N+14
        checks++;
        if (bus.score !== 16'h0030 || bus.highScore !== 16'h0030) begin
            errors++;
            $display("FAIL latency_commit: score=%h hs=%h, want 0030/0030", bus.score, bus.highScore);
        end
        @(posedge clk); #1;                   // edge N+15
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL latency_busy: busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_queue();
        start_game();
        @(negedge clk) bus.scoreUpdate = 8'd100;
        @(posedge clk);                       // edge N
        @(negedge clk) bus.scoreUpdate = 8'd0;
        @(negedge clk) bus.scoreUpdate = 8'd20;
        @(negedge clk) bus.scoreUpdate = 8'd0;
        @(negedge clk) bus.scoreUpdate = 8'd10;
        @(negedge clk) bus.scoreUpdate = 8'd0; // after edge N+4
        repeat (9) @(posedge clk); #1;         // N+13
        checks++;
        if (bus.score !== 16'h0000) begin errors++; $display("FAIL queue_n13: score=%h, want 0000", bus.score); end
        @(posedge clk); #1;                    // N+14
        checks++;
        if (bus.score !== 16'h0100) begin errors++; $display("FAIL queue_n14: score=%h, want 0100", bus.score); end
        repeat (13) @(posedge clk); #1;        // N+27
        checks++;
        if (bus.score !== 16'h0100) begin errors++; $display("FAIL queue_n27: score=%h, want 0100", bus.score); end
        @(posedge clk); #1;                    // N+28
        checks++;
        if (bus.score !== 16'h0120) begin errors++; $display("FAIL queue_n28: score=%h, want 0120", bus.score); end
        repeat (13) @(posedge clk); #1;        // N+41
        checks++;
        if (bus.score !== 16'h0120) begin errors++; $display("FAIL queue_n41: score=%h, want 0120", bus.score); end
        @(posedge clk); #1;                    // N+42
        checks++;
        if (bus.score !== 16'h0130 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL queue_n42: score=%h ovf=%b, want 0130/0", bus.score, bus.overflow);
        end
    endtask

    task automatic test_overflow();
        int n;
        start_game();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk) bus.scoreUpdate = 8'd10;
            @(negedge clk) bus.scoreUpdate = 8'd0;
        end
        checks++;
        if (bus.overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag: ovf=%b, want 1", bus.overflow); end
        n = 0;
        while (bus.busy && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL overflow_timeout: busy=%b after %0d cycles, want 0", bus.busy, n); end
        checks++;
        if (bus.score !== 16'h0050) begin errors++; $display("FAIL overflow_score: score=%h, want 0050", bus.score); end
        start_game();
        checks++;
        if (bus.overflow !== 1'b0 || bus.score !== 16'h0000) begin
            errors++;
            $display("FAIL overflow_clear: ovf=%b score=%h, want 0/0000", bus.overflow, bus.score);
        end
    endtask

    task automatic test_saturate();
        int p;
        start_game();
        for (int i = 0; i < 39; i++) send(8'd255, p); // 9945
        send(8'd45, p);
        checks++;
        if (bus.score !== 16'h9990) begin errors++; $display("FAIL sat_preload: score=%h, want 9990", bus.score); end
        send(8'd30, p);
        checks++;
        if (bus.score !== 16'h9999 || bus.highScore !== 16'h9999) begin
            errors++;
            $display("FAIL sat_clip: score=%h hs=%h, want 9999/9999", bus.score, bus.highScore);
        end
        send(8'd10, p);
        checks++;
        if (bus.score !== 16'h9999) begin errors++; $display("FAIL sat_hold: score=%h, want 9999", bus.score); end
    endtask

    task automatic test_extra_life();
        int p, tot;
        start_game();
        tot = 0;
        for (int i = 0; i < 5; i++) begin send(8'd255, p); tot += p; end // 1275
        send(8'd215, p); tot += p;                                         // 1490
        checks++;
        if (bus.score !== 16'h1490 || tot !== 0) begin
            errors++;
            $display("FAIL life_below: score=%h pulses=%0d, want 1490/0", bus.score, tot);
        end
        send(8'd20, p);
        checks++;
        if (bus.score !== 16'h1510 || p !== 1) begin
            errors++;
            $display("FAIL life_cross: score=%h pulses=%0d, want 1510/1", bus.score, p);
        end
        send(8'd10, p);
        checks++;
        if (bus.score !== 16'h1520 || p !== 0) begin
            errors++;
            $display("FAIL life_once: score=%h pulses=%0d, want 1520/0", bus.score, p);
        end
        start_game();
        tot = 0;
        for (int i = 0; i < 5; i++) begin send(8'd255, p); tot += p; end
        send(8'd225, p); tot += p;                                         // 1500
        checks++;
        if (bus.score !== 16'h1500 || tot !== 1) begin
            errors++;
            $display("FAIL life_newgame: score=%h pulses=%0d, want 1500/1", bus.score, tot);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk) bus.scoreUpdate = 8'd50;
        @(negedge clk) bus.scoreUpdate = 8'd0;
        repeat (3) @(posedge clk);
        #3 resetN = 1'b0;
        #1;
        checks++;
        if (bus.score !== 16'h0 || bus.highScore !== 16'h0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: score=%h hs=%h busy=%b, want 0000/0000/0",
                     bus.score, bus.highScore, bus.busy);
        end
        @(negedge clk) resetN = 1'b1;
    endtask

    task automatic test_flush_and_gating();
        int p;
        send(8'd250, p);
        checks++;
        if (bus.score !== 16'h0250 || bus.highScore !== 16'h0250) begin
            errors++;
            $display("FAIL flush_setup: score=%h hs=%h, want 0250/0250", bus.score, bus.highScore);
        end
        @(negedge clk) bus.scoreUpdate = 8'd40;
        @(posedge clk);                        // edge N
        @(negedge clk) bus.scoreUpdate = 8'd0;
        repeat (3) @(posedge clk);             // N+3, in CONV
        @(negedge clk) bus.startGame = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.score !== 16'h0000 || bus.highScore !== 16'h0250 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_now: score=%h hs=%h busy=%b, want 0000/0250/0",
                     bus.score, bus.highScore, bus.busy);
        end
        @(negedge clk) bus.startGame = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.score !== 16'h0000) begin errors++; $display("FAIL flush_nocommit: score=%h, want 0000", bus.score); end
        bus.standBy = 1'b1;
        send(8'd10, p);
        bus.standBy = 1'b0;
        checks++;
        if (bus.score !== 16'h0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL gate_standby: score=%h busy=%b, want 0000/0", bus.score, bus.busy);
        end
        bus.gameEnded = 1'b1;
        send(8'd10, p);
        bus.gameEnded = 1'b0;
        checks++;
        if (bus.score !== 16'h0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL gate_ended: score=%h busy=%b, want 0000/0", bus.score, bus.busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_latency();
        test_queue();
        test_overflow();
        test_saturate();
        test_extra_life();
        test_async_reset();
        test_flush_and_gating();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
